// File: rtl/trace_monitor.sv
// Execution trace monitor: captures per-cycle CPU commit records into a FWFT FIFO.
// Optional watch-channel change tracking is enabled with `define TRACE_WATCH_EN.
module trace_monitor #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_WATCH = 4,
  parameter int unsigned TIMEOUT   = 60
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [31:0]               pc,
  input  logic [31:0]               instr,
  input  logic [31:0]               alu_result,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [32*NUM_WATCH-1:0]   watch_data,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [127+NUM_WATCH:0]    rd_record,
  output logic [31:0]               cycle_count,
  output logic                      halted,
  output logic [15:0]               overflow
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned REC_W = 128 + NUM_WATCH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]           state;
  logic [31:0]          cnt_next;
  logic                 capture;
  logic [NUM_WATCH-1:0] watch_chg;
  logic [REC_W-1:0]     rec_in;

  logic [AW:0]          wptr, rptr;
  logic                 empty, full, pop, wr, drop;
  logic [REC_W-1:0]     mem [DEPTH];

  // The edge that sees en=1 in IDLE already captures, so the first record carries cycle=1.
  assign capture  = en && (state != HALT);
  assign cnt_next = cycle_count + 32'd1;
  assign halted   = (state == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (capture) begin
            cycle_count <= cnt_next;
            state       <= (cnt_next == TIMEOUT) ? HALT : RUN;
          end else begin
            state <= IDLE;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRACE_WATCH_EN
  logic [32*NUM_WATCH-1:0] snap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap <= '0;
    end else if (capture) begin
      snap <= watch_data;
    end
  end

  always_comb begin
    watch_chg = '0;
    for (int unsigned k = 0; k < NUM_WATCH; k++) begin
      watch_chg[k] = (watch_data[32*k +: 32] != snap[32*k +: 32]);
    end
  end
`else
  logic unused_watch;
  assign unused_watch = ^watch_data;
  assign watch_chg    = '0;
`endif

  logic unused_alu;
  assign unused_alu = ^alu_result[1:0];

  assign rec_in = {cnt_next, pc, instr, alu_result[31:2], mem_write, mem_read, watch_chg};

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop      = !empty && rd_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign wr       = capture && (!full || pop);
  assign drop     = capture && full && !pop;
  assign rd_valid = !empty;
  assign rd_record = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr[AW-1:0]] <= rec_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
      if (drop && (overflow != '1)) begin
        overflow <= overflow + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_trace_monitor.sv
// Self-checking bench for trace_monitor: phase table, queue-based reference model, corner sequences.
module tb_trace_monitor;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned NW    = 4;
  localparam int unsigned TO    = 60;
  localparam int unsigned RW    = 128 + NW;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [31:0]     pc, instr, alu_result;
  logic            mem_read, mem_write;
  logic [32*NW-1:0] watch_data;
  logic            rd_ready;
  logic            rd_valid;
  logic [RW-1:0]   rd_record;
  logic [31:0]     cycle_count;
  logic            halted;
  logic [15:0]     overflow;

  always #5 clk = ~clk;

  trace_monitor #(.DEPTH(DEPTH), .NUM_WATCH(NW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .en(en), .pc(pc), .instr(instr), .alu_result(alu_result),
    .mem_read(mem_read), .mem_write(mem_write), .watch_data(watch_data), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_record(rd_record), .cycle_count(cycle_count),
    .halted(halted), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  bit rand_bus = 1'b1;

  // Reference model: queue of pending records plus counters
  logic [RW-1:0] mq[$];
  int unsigned   m_cnt;
  bit            m_halt;
  int unsigned   m_ovf;
  logic [31:0]   m_snap[NW];

  typedef struct {
    bit          en;
    bit          rdy;
    int unsigned n;
    int unsigned exp_cc;
    bit          exp_valid;
    int unsigned exp_ovf;
    bit          exp_halt;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt  = 0;
    m_halt = 1'b0;
    m_ovf  = 0;
    for (int k = 0; k < NW; k++) m_snap[k] = '0;
  endtask

  task automatic model_edge();
    bit            do_pop;
    logic [NW-1:0] chg;
    do_pop = (mq.size() > 0) && rd_ready;
    chg    = '0;
    if (do_pop) void'(mq.pop_front());
    if (en && !m_halt) begin
      for (int k = 0; k < NW; k++) begin
`ifdef TRACE_WATCH_EN
        chg[k]    = (watch_data[32*k +: 32] != m_snap[k]);
        m_snap[k] = watch_data[32*k +: 32];
`endif
      end
      m_cnt++;
      if (mq.size() < DEPTH)
        mq.push_back({m_cnt[31:0], pc, instr, alu_result[31:2], mem_write, mem_read, chg});
      else if (m_ovf < 65535)
        m_ovf++;
      if (m_cnt == TO) m_halt = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("rd_valid", rd_valid, mq.size() > 0);
    if (mq.size() > 0) chk("rd_record", rd_record, mq[0]);
    chk("cycle_count", cycle_count, m_cnt);
    chk("halted", halted, m_halt);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic step();
    if (rand_bus) begin
      pc         = $urandom;
      instr      = $urandom;
      alu_result = $urandom;
      mem_read   = 1'($urandom);
      mem_write  = 1'($urandom);
      for (int k = 0; k < NW; k++) watch_data[32*k +: 32] = $urandom_range(0, 3);
    end
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("reset rd_valid", rd_valid, 1'b0);
    chk("reset cycle_count", cycle_count, 32'd0);
    chk("reset halted", halted, 1'b0);
    chk("reset overflow", overflow, 16'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int unsigned pops;
    logic [NW-1:0] exp_chg;

    tbl[0] = '{1'b1, 1'b0, 5,  5,  1'b1, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 3,  5,  1'b1, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 15, 20, 1'b1, 4, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 10, 30, 1'b1, 4, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 20, 30, 1'b0, 4, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 30, 60, 1'b1, 4, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 5,  60, 1'b1, 4, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 2,  60, 1'b0, 4, 1'b1};

    en = 1'b0; rd_ready = 1'b0; pc = '0; instr = '0; alu_result = '0;
    mem_read = 1'b0; mem_write = 1'b0; watch_data = '0;
    #3;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      en       = tbl[i].en;
      rd_ready = tbl[i].rdy;
      for (int c = 0; c < int'(tbl[i].n); c++) step();
      chk($sformatf("phase%0d cycle_count", i), cycle_count, tbl[i].exp_cc);
      chk($sformatf("phase%0d rd_valid", i), rd_valid, tbl[i].exp_valid);
      chk($sformatf("phase%0d overflow", i), overflow, tbl[i].exp_ovf);
      chk($sformatf("phase%0d halted", i), halted, tbl[i].exp_halt);
      if (i == 0 || i == 2) chk($sformatf("phase%0d head cycle", i), rd_record[RW-1 -: 32], 32'd1);
    end

    // Timeout with continuous draining
    en = 1'b0; rd_ready = 1'b0;
    do_reset();
    en = 1'b1; rd_ready = 1'b1; pops = 0;
    for (int c = 1; c <= 62; c++) begin
      if (rd_valid && rd_ready) pops++;
      step();
      if (c == 59) chk("halted before timeout", halted, 1'b0);
      if (c == 60) chk("halted after timeout", halted, 1'b1);
    end
    chk("timeout pops", pops, 60);
    chk("timeout cycle_count", cycle_count, 32'd60);

    // Watch channel 1 steps 0->7 on the third captured cycle
    en = 1'b0; rd_ready = 1'b0;
    do_reset();
    rand_bus = 1'b0;
    watch_data = '0;
    en = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) watch_data[63:32] = 32'd7;
      step();
    end
    en = 1'b0; rd_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      exp_chg = '0;
`ifdef TRACE_WATCH_EN
      if (c == 3) exp_chg = 4'b0010;
`endif
      chk($sformatf("watch_chg rec%0d", c), rd_record[NW-1:0], exp_chg);
      step();
    end
    rand_bus = 1'b1;

    // Asynchronous reset in the middle of a run
    rd_ready = 1'b0; en = 1'b1;
    for (int c = 0; c < 4; c++) step();
    #2;
    reset = 1'b0;
    #1;
    chk("midrun reset rd_valid", rd_valid, 1'b0);
    chk("midrun reset cycle_count", cycle_count, 32'd0);
    chk("midrun reset halted", halted, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post-reset first cycle", rd_record[RW-1 -: 32], 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
